// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-port FIFO: owns the read pointer and feeds
// a registered show-ahead output stage with valid/ready, plus fill status.
module fifo_rd_ctrl #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned ASIZE     = 4,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic [ASIZE:0]   rq2_wptr,
   input  logic [DSIZE-1:0] rdata_mem,
   output logic [ASIZE-1:0] raddr,
   output logic [ASIZE:0]   rptr,
   output logic             rempty,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   input  logic             out_ready,
   output logic             raempty,
   output logic [ASIZE:0]   rcount,
   output logic             rerr
);

   localparam int unsigned PW    = ASIZE + 1;
   localparam int unsigned DEPTH = 1 << ASIZE;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = '0;
      for (int i = 0; i < int'(PW); i++) b[i] = ^(g >> i);
      return b;
   endfunction

   logic [PW-1:0] rbin;
   logic [PW-1:0] rbin_next;
   logic [PW-1:0] wbin;
   logic [PW-1:0] rcount_next;
   logic          perr;
   logic          pop;

   // Status and pop decision from the current registered state only.
   always_comb begin
      wbin        = gray2bin(rq2_wptr);
      rcount      = wbin - rbin;
      rempty      = (rptr == rq2_wptr);
      perr        = 32'(rcount) > DEPTH;
      pop         = !rempty && !perr && (!out_valid || out_ready);
      rbin_next   = rbin + PW'(pop);
      rcount_next = wbin - rbin_next;
   end

   assign raddr = rbin[ASIZE-1:0];

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin      <= '0;
         rptr      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         raempty   <= 1'b1;
         rerr      <= 1'b0;
      end else begin
         rbin    <= rbin_next;
         rptr    <= bin2gray(rbin_next);
         raempty <= 32'(rcount_next) <= AEMPTY_TH;
         if (perr) rerr <= 1'b1;
         // Refill in the same cycle the stage drains so streaming has no bubbles.
         if (pop) begin
            out_data  <= rdata_mem;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl against a queue-based model of the FIFO
// contents and the output stage.
module tb_fifo_rd_ctrl;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned ASIZE = 4;
   localparam int unsigned TH    = 2;

   logic             rclk = 1'b0;
   logic             rrst;
   logic [ASIZE:0]   rq2_wptr;
   logic [DSIZE-1:0] rdata_mem;
   logic [ASIZE-1:0] raddr;
   logic [ASIZE:0]   rptr;
   logic             rempty;
   logic             out_valid;
   logic [DSIZE-1:0] out_data;
   logic             out_ready;
   logic             raempty;
   logic [ASIZE:0]   rcount;
   logic             rerr;

   logic [DSIZE-1:0] mem [16];

   // Reference state: unread words in memory, output stage, pointer counts.
   logic [DSIZE-1:0] mq[$];
   logic             mv;
   logic [DSIZE-1:0] md;
   int               rd_n;
   int               wr_n;
   int               n_cmp = 0;
   int               n_err = 0;

   fifo_rd_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AEMPTY_TH(TH)) dut (
      .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
      .raddr(raddr), .rptr(rptr), .rempty(rempty), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .raempty(raempty),
      .rcount(rcount), .rerr(rerr)
   );

   always #5 rclk = ~rclk;
   assign rdata_mem = mem[raddr];

   function automatic logic [ASIZE:0] gray(input int n);
      logic [ASIZE:0] b;
      b = (ASIZE+1)'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mv   = 1'b0;
      md   = '0;
      rd_n = 0;
      wr_n = 0;
   endtask

   // Called just after an edge: write nw words, set ready, run one clock, check.
   task automatic step(input logic rdy, input int nw);
      logic [ASIZE:0] prev;
      bit popped;
      for (int i = 0; i < nw; i++) begin
         if (mq.size() < 16) begin
            mem[wr_n % 16] = DSIZE'($urandom);
            mq.push_back(mem[wr_n % 16]);
            wr_n++;
         end
      end
      rq2_wptr  = gray(wr_n);
      out_ready = rdy;
      #1;
      chk("rcount", 32'(rcount), 32'(mq.size()));
      chk("rempty", 32'(rempty), 32'(mq.size() == 0));
      prev   = rptr;
      popped = 0;
      if (mq.size() > 0 && (!mv || rdy)) begin
         md = mq.pop_front();
         mv = 1'b1;
         rd_n++;
         popped = 1;
      end else if (mv && rdy) begin
         mv = 1'b0;
      end
      @(posedge rclk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("out_data", 32'(out_data), 32'(md));
      chk("rptr", 32'(rptr), 32'(gray(rd_n)));
      chk("rptr_bits", 32'($countones(rptr ^ prev)), 32'(popped));
      chk("raddr", 32'(raddr), 32'(rd_n % 16));
      chk("raempty", 32'(raempty), 32'(mq.size() <= TH));
      chk("rerr", 32'(rerr), 32'd0);
   endtask

   task automatic do_reset();
      rrst      = 1'b1;
      rq2_wptr  = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge rclk);
      #1;
      rrst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rrst      = 1'b0;
      rq2_wptr  = '0;
      out_ready = 1'b0;
      model_reset();
      do_reset();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_raempty", 32'(raempty), 32'd1);
      chk("rst_rempty", 32'(rempty), 32'd1);

      // Single entry, then idle with backpressure.
      mem[0] = 8'hA5;
      mq.push_back(8'hA5);
      wr_n = 1;
      step(1'b0, 0);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_rptr", 32'(rptr), 32'b00001);
      for (int i = 0; i < 5; i++) step(1'b0, 0);

      // Asynchronous reset mid-cycle while holding a word.
      #2;
      rrst     = 1'b1;
      rq2_wptr = '0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_rptr", 32'(rptr), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_raempty", 32'(raempty), 32'd1);
      chk("arst_rempty", 32'(rempty), 32'd1);
      do_reset();

      // Backpressure: three entries, one pop, then drain.
      step(1'b0, 3);
      chk("bp_rcount", 32'(rcount), 32'd2);
      for (int i = 0; i < 4; i++) step(1'b1, 0);

      // Streaming across the address wrap.
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 0);
      chk("stream_rptr", 32'(rptr), 32'(gray(20)));

      // Almost-empty while draining from five.
      do_reset();
      step(1'b0, 6);
      for (int i = 0; i < 8; i++) step(1'b1, 0);

      // Corrupt pointer: sticky error, no pop.
      do_reset();
      rq2_wptr = 5'b11001;
      #1;
      chk("perr_rcount", 32'(rcount), 32'd17);
      @(posedge rclk);
      #1;
      chk("perr_rerr", 32'(rerr), 32'd1);
      chk("perr_valid", 32'(out_valid), 32'd0);
      chk("perr_rptr", 32'(rptr), 32'd0);
      rq2_wptr = '0;
      repeat (2) @(posedge rclk);
      #1;
      chk("perr_sticky", 32'(rerr), 32'd1);
      do_reset();
      chk("perr_clear", 32'(rerr), 32'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
      for (int i = 0; i < 20; i++) step(1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
